// File: rtl/bcd_display_scan_if.sv
// bcd_display_scan_if: latch/value in, multiplexed segment/enable/error out
interface bcd_display_scan_if;
  logic        latch;
  logic [11:0] bcd_in;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        err;
  modport master (output latch, bcd_in, input seg, an, err);
  modport slave (input latch, bcd_in, output seg, an, err);
endinterface

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: 3-digit BCD shadow register scanned onto a common-anode 7-seg display
module bcd_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic               clk,
  input logic               rst,
  bcd_display_scan_if.slave bus
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   sh_q, sh_d;
  logic [6:0]    seg_q, seg_d, tbl;
  logic [2:0]    an_q, an_d;
  logic          err_q, err_d;
  logic [3:0]    nib;
  logic          wrap, blank;
  always_comb begin
    wrap  = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? (idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1) : idx_q;
    sh_d  = bus.latch ? bus.bcd_in : sh_q;
    nib   = idx_q == 2'd0 ? sh_q[3:0] : idx_q == 2'd1 ? sh_q[7:4] : sh_q[11:8];
    blank = BLANK_LZ && ((idx_q == 2'd2 && sh_q[11:8] == 4'd0) ||
                         (idx_q == 2'd1 && sh_q[11:4] == 8'd0));
    case (nib)
      4'd0:    tbl = 7'h40;
      4'd1:    tbl = 7'h79;
      4'd2:    tbl = 7'h24;
      4'd3:    tbl = 7'h30;
      4'd4:    tbl = 7'h19;
      4'd5:    tbl = 7'h12;
      4'd6:    tbl = 7'h02;
      4'd7:    tbl = 7'h78;
      4'd8:    tbl = 7'h00;
      4'd9:    tbl = 7'h10;
      default: tbl = 7'h3F;
    endcase
    seg_d = blank ? 7'h7F : tbl;
    an_d  = blank ? 3'b111 : idx_q == 2'd0 ? 3'b110 : idx_q == 2'd1 ? 3'b101 :
            idx_q == 2'd2 ? 3'b011 : 3'b111;
    err_d = sh_q[3:0] > 4'd9 || sh_q[7:4] > 4'd9 || sh_q[11:8] > 4'd9;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      sh_q  <= 12'h000;
      seg_q <= 7'h7F;
      an_q  <= 3'b111;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      err_q <= err_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed scan/blanking/latch/reset checks plus a cycle scoreboard
module tb_bcd_display_scan;
  logic        clk = 1'b0, rst = 1'b1, latch = 1'b0;
  logic [11:0] bcd = 12'h000;
  int          checks = 0, failures = 0, k = 0;
  logic [10:0] q[$];
  logic [1:0]  m_idx;
  logic [1:0]  m_cnt;
  logic [11:0] m_sh;
  localparam logic [6:0] SEGS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  bcd_display_scan_if b1 ();
  bcd_display_scan_if b0 ();
  assign b1.latch = latch;
  assign b1.bcd_in = bcd;
  assign b0.latch = latch;
  assign b0.bcd_in = bcd;
  bcd_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (.clk(clk), .rst(rst), .bus(b1));
  bcd_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(b0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got an/seg/err=%h required=%h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] model(input logic [1:0] idx, input logic [11:0] sh);
    logic [3:0] n;
    logic e, bl;
    n  = idx == 2'd0 ? sh[3:0] : idx == 2'd1 ? sh[7:4] : sh[11:8];
    e  = sh[3:0] > 4'd9 || sh[7:4] > 4'd9 || sh[11:8] > 4'd9;
    bl = (idx == 2'd2 && sh[11:8] == 4'd0) || (idx == 2'd1 && sh[11:4] == 8'd0);
    return bl ? {3'b111, 7'h7F, e} :
           {idx == 2'd0 ? 3'b110 : idx == 2'd1 ? 3'b101 : 3'b011, SEGS[n], e};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_idx = 2'd0;
      m_cnt = 2'd0;
      m_sh  = 12'h000;
    end else begin
      q.push_back(model(m_idx, m_sh));
      if (latch) m_sh = bcd;
      if (m_cnt == 2'd3) m_idx = m_idx == 2'd2 ? 2'd0 : m_idx + 2'd1;
      m_cnt = m_cnt + 2'd1;
    end
  end
  always @(negedge clk) begin
    if (rst) chk("reset_hold", {b1.an, b1.seg, b1.err}, {3'b111, 7'h7F, 1'b0});
    else if (q.size() > 0) chk("scoreboard", {b1.an, b1.seg, b1.err}, q.pop_front());
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask
  task automatic to_slot(input int s, input int off);
    tick(1);
    while (((k - 1) / 4) % 3 != s || (k - 1) % 4 != off) tick(1);
  endtask
  task automatic do_latch(input logic [11:0] v);
    latch = 1'b1;
    bcd = v;
    tick(1);
    latch = 1'b0;
    tick(1);
  endtask
  task automatic look(input string tag, input logic [2:0] an, input logic [6:0] seg, input logic err);
    chk(tag, {b1.an, b1.seg, b1.err}, {an, seg, err});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    look("reset", 3'b111, 7'h7F, 1'b0);
    rst = 1'b0;
    k = 0;
    tick(1);
    look("first_units", 3'b110, 7'h40, 1'b0);
    to_slot(1, 0); look("zero_tens_blank", 3'b111, 7'h7F, 1'b0);
    to_slot(2, 0); look("zero_hund_blank", 3'b111, 7'h7F, 1'b0);
    to_slot(0, 0); do_latch(12'h259);
    look("259_units", 3'b110, 7'h10, 1'b0);
    to_slot(1, 0); look("259_tens", 3'b101, 7'h12, 1'b0);
    to_slot(2, 3); look("259_hund", 3'b011, 7'h24, 1'b0);
    to_slot(0, 0); look("259_units_again", 3'b110, 7'h10, 1'b0);
    do_latch(12'h070);
    to_slot(2, 0); look("070_hund_blank", 3'b111, 7'h7F, 1'b0);
    to_slot(0, 0); look("070_units", 3'b110, 7'h40, 1'b0);
    to_slot(1, 0); look("070_tens", 3'b101, 7'h78, 1'b0);
    do_latch(12'h100);
    to_slot(2, 0); look("100_hund", 3'b011, 7'h79, 1'b0);
    to_slot(0, 0); look("100_units", 3'b110, 7'h40, 1'b0);
    to_slot(1, 0); look("100_tens", 3'b101, 7'h40, 1'b0);
    do_latch(12'h007);
    to_slot(2, 0);
    look("007_hund_blank", 3'b111, 7'h7F, 1'b0);
    chk("007_hund_noblank", {b0.an, b0.seg, b0.err}, {3'b011, 7'h40, 1'b0});
    to_slot(1, 0);
    chk("007_tens_noblank", {b0.an, b0.seg, b0.err}, {3'b101, 7'h40, 1'b0});
    to_slot(1, 0); do_latch(12'h0A3);
    look("0A3_tens_err", 3'b101, 7'h3F, 1'b1);
    to_slot(0, 0); look("0A3_units", 3'b110, 7'h30, 1'b1);
    to_slot(1, 0); do_latch(12'h123);
    look("123_tens", 3'b101, 7'h24, 1'b0);
    bcd = 12'h999;
    to_slot(0, 0); look("gated_units", 3'b110, 7'h30, 1'b0);
    to_slot(2, 0); look("gated_hund", 3'b011, 7'h79, 1'b0);
    to_slot(0, 1); do_latch(12'h888);
    look("888_mid_units", 3'b110, 7'h00, 1'b0);
    tick(1); look("888_tens_on_time", 3'b101, 7'h00, 1'b0);
    to_slot(2, 1);
    #2 rst = 1'b1;
    #1 look("async_reset", 3'b111, 7'h7F, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    tick(1); look("restart_units", 3'b110, 7'h40, 1'b0);
    to_slot(1, 0); look("restart_tens_clear", 3'b111, 7'h7F, 1'b0);
    to_slot(2, 0); look("restart_hund_clear", 3'b111, 7'h7F, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
